// File: rtl/pic_irr_ctrl.sv
// Interrupt request register for an 8259A-style PIC: synchronises IR lines, latches them
// edge- or level-triggered, clears on acknowledge and resolves the winning request.
module pic_irr_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               LTIM,
  input  logic [NUM_IRQ-1:0] ir,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               ack_valid,
  input  logic [ID_W-1:0]    ack_id,
  input  logic               rotate_en,
  output logic [NUM_IRQ-1:0] irr,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id
);

  localparam logic [2:0] WARM_INIT = 3'(SYNC_STAGES + 1);

  logic [NUM_IRQ-1:0] sync_p [SYNC_STAGES];
  logic [NUM_IRQ-1:0] ir_s;
  logic [NUM_IRQ-1:0] ir_prev;
  logic [NUM_IRQ-1:0] irr_nxt;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] pending;
  logic [ID_W-1:0]    prio_base;
  logic [ID_W:0]      win;
  logic [2:0]         warm_cnt;
  logic               ltim_q;
  logic               ack_ok;

  // Returns {found, index}: first set bit scanning upward from base with wrap.
  function automatic logic [ID_W:0] find_winner(input logic [NUM_IRQ-1:0] p,
                                                 input logic [ID_W-1:0]    base);
    logic          found;
    logic [ID_W-1:0] id;
    found = 1'b0;
    id    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      int idx;
      idx = int'(base) + i;
      if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
      if (!found && p[idx]) begin
        found = 1'b1;
        id    = ID_W'(idx);
      end
    end
    return {found, id};
  endfunction

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
    return (int'(id) == NUM_IRQ - 1) ? '0 : id + 1'b1;
  endfunction

  assign ir_s    = sync_p[SYNC_STAGES-1];
  assign ack_ok  = ack_valid && (int'(ack_id) < NUM_IRQ);
  assign ack_clr = ack_ok ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << ack_id) : '0;
  assign pending = irr & ~imr;
  assign win     = find_winner(pending, prio_base);

  // Warm-up and mode changes flush the register; otherwise set-wins-over-ack in edge mode.
  always_comb begin
    irr_nxt = irr;
    if (warm_cnt != 3'd0 || LTIM != ltim_q) begin
      irr_nxt = '0;
    end else if (LTIM) begin
      irr_nxt = ir_s;
    end else begin
      irr_nxt = (irr & ~ack_clr) | (ir_s & ~ir_prev);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      ir_prev   <= '0;
      irr       <= '0;
      int_req   <= 1'b0;
      int_id    <= '0;
      prio_base <= '0;
      ltim_q    <= 1'b0;
      warm_cnt  <= WARM_INIT;
    end else begin
      sync_p[0] <= ir;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      ir_prev <= ir_s;
      ltim_q  <= LTIM;
      irr     <= irr_nxt;
      int_req <= win[ID_W];
      int_id  <= win[ID_W-1:0];
      if (warm_cnt != 3'd0) warm_cnt <= warm_cnt - 3'd1;
      if (ack_ok && rotate_en) prio_base <= wrap_inc(ack_id);
    end
  end

endmodule

// File: tb/tb_pic_irr_ctrl.sv
// Directed bench for pic_irr_ctrl: stimulus queues expected (irr, int_req, int_id) per cycle,
// a negedge monitor pops and compares them.
module tb_pic_irr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       LTIM;
  logic [7:0] ir;
  logic [7:0] imr;
  logic       ack_valid;
  logic [2:0] ack_id;
  logic       rotate_en;
  logic [7:0] irr;
  logic       int_req;
  logic [2:0] int_id;

  typedef struct {
    int         cyc;
    string      nm;
    logic [7:0] irr;
    logic       req;
    logic [2:0] id;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  pic_irr_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .LTIM(LTIM), .ir(ir), .imr(imr),
    .ack_valid(ack_valid), .ack_id(ack_id), .rotate_en(rotate_en),
    .irr(irr), .int_req(int_req), .int_id(int_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", e.nm, e.cyc, cyc);
      end else if ({irr, int_req, int_id} !== {e.irr, e.req, e.id}) begin
        n_bad++;
        $display("FAIL %s @%0d: got irr=%h req=%b id=%0d, want irr=%h req=%b id=%0d",
                 e.nm, cyc, irr, int_req, int_id, e.irr, e.req, e.id);
      end
    end
  end

  task automatic expect_at(input int k, input string nm, input logic [7:0] ei,
                           input logic er, input logic [2:0] ed);
    exp_t e;
    e.cyc = cyc + k;
    e.nm  = nm;
    e.irr = ei;
    e.req = er;
    e.id  = ed;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; LTIM = 1'b0; ir = 8'h01; imr = 8'h00;
    ack_valid = 1'b0; ack_id = 3'd0; rotate_en = 1'b0;
    tick(3);
    expect_at(0, "reset_state", 8'h00, 1'b0, 3'd0);
    reset = 1'b0;
    expect_at(3,  "held_line_warmup", 8'h00, 1'b0, 3'd0);
    expect_at(5,  "held_line_mid",    8'h00, 1'b0, 3'd0);
    expect_at(10, "held_line_no_edge", 8'h00, 1'b0, 3'd0);
    tick(10);

    // Edge mode: latency, hold after line drop, clear on ack.
    ir = 8'h09;
    expect_at(2, "edge_not_yet",  8'h00, 1'b0, 3'd0);
    expect_at(3, "edge_latency",  8'h08, 1'b0, 3'd0);
    expect_at(4, "edge_int_req",  8'h08, 1'b1, 3'd3);
    tick(4);
    ir = 8'h00;
    expect_at(5, "edge_hold", 8'h08, 1'b1, 3'd3);
    tick(5);
    ack_valid = 1'b1; ack_id = 3'd3;
    expect_at(1, "edge_ack_clear", 8'h00, 1'b1, 3'd3);
    expect_at(2, "edge_ack_intreq", 8'h00, 1'b0, 3'd0);
    tick(1);
    ack_valid = 1'b0;
    tick(1);

    // Level mode: follows lines, ack ignored.
    LTIM = 1'b1;
    expect_at(1, "lvl_mode_change", 8'h00, 1'b0, 3'd0);
    tick(3);
    ir = 8'h24;
    expect_at(2, "lvl_not_yet",  8'h00, 1'b0, 3'd0);
    expect_at(3, "lvl_latency",  8'h24, 1'b0, 3'd0);
    expect_at(4, "lvl_int_id",   8'h24, 1'b1, 3'd2);
    tick(4);
    ack_valid = 1'b1; ack_id = 3'd2;
    expect_at(1, "lvl_ack_noeffect", 8'h24, 1'b1, 3'd2);
    expect_at(2, "lvl_ack_noeffect2", 8'h24, 1'b1, 3'd2);
    tick(1);
    ack_valid = 1'b0;
    tick(1);
    ir = 8'h00;
    expect_at(2, "lvl_drop_wait", 8'h24, 1'b1, 3'd2);
    expect_at(3, "lvl_drop",      8'h00, 1'b1, 3'd2);
    expect_at(4, "lvl_drop_req",  8'h00, 1'b0, 3'd0);
    tick(5);

    // Masking.
    ir = 8'h81; imr = 8'h01;
    expect_at(3, "mask_irr",   8'h81, 1'b0, 3'd0);
    expect_at(4, "mask_bit0",  8'h81, 1'b1, 3'd7);
    tick(4);
    imr = 8'h00;
    expect_at(1, "mask_none", 8'h81, 1'b1, 3'd0);
    tick(1);
    imr = 8'hFF;
    expect_at(1, "mask_all",  8'h81, 1'b0, 3'd0);
    tick(1);

    // Rotating priority.
    imr = 8'h00; ir = 8'h0B;
    expect_at(4, "rot_start", 8'h0B, 1'b1, 3'd0);
    tick(4);
    ack_valid = 1'b1; rotate_en = 1'b1; ack_id = 3'd1;
    expect_at(1, "rot_ack1_lag",  8'h0B, 1'b1, 3'd0);
    expect_at(2, "rot_base2",     8'h0B, 1'b1, 3'd3);
    tick(1);
    ack_id = 3'd7;
    expect_at(1, "rot_ack7_lag",  8'h0B, 1'b1, 3'd3);
    expect_at(2, "rot_wrap_base0", 8'h0B, 1'b1, 3'd0);
    tick(1);
    ack_id = 3'd2;
    expect_at(1, "rot_ack2_lag",  8'h0B, 1'b1, 3'd0);
    expect_at(2, "rot_base3",     8'h0B, 1'b1, 3'd3);
    tick(1);
    ack_valid = 1'b0; rotate_en = 1'b0;
    tick(1);
    ack_valid = 1'b1; ack_id = 3'd5;
    expect_at(2, "fixed_keeps_base", 8'h0B, 1'b1, 3'd3);
    tick(1);
    ack_valid = 1'b0;
    tick(1);
    ir = 8'h03;
    expect_at(3, "wrap_scan_irr", 8'h03, 1'b1, 3'd3);
    expect_at(4, "wrap_scan_id",  8'h03, 1'b1, 3'd0);
    tick(5);

    // Back to edge mode with lines held high: flush, no spurious edges.
    LTIM = 1'b0;
    expect_at(1, "to_edge_flush",  8'h00, 1'b1, 3'd0);
    expect_at(2, "to_edge_req",    8'h00, 1'b0, 3'd0);
    expect_at(5, "to_edge_noset",  8'h00, 1'b0, 3'd0);
    tick(5);

    // New edge on the bit being acknowledged: set wins.
    ir = 8'h23;
    expect_at(3, "edge5_set", 8'h20, 1'b0, 3'd0);
    tick(3);
    ir = 8'h03;
    tick(2);
    ir = 8'h23;
    tick(2);
    ack_valid = 1'b1; ack_id = 3'd5;
    expect_at(1, "set_wins_ack",  8'h20, 1'b1, 3'd5);
    expect_at(2, "set_wins_ack2", 8'h20, 1'b1, 3'd5);
    tick(1);
    ack_valid = 1'b0;
    tick(1);
    ack_valid = 1'b1;
    expect_at(1, "ack5_clear",  8'h00, 1'b1, 3'd5);
    expect_at(2, "ack5_intreq", 8'h00, 1'b0, 3'd0);
    tick(1);
    ack_valid = 1'b0;
    tick(1);

    // irr=FF then LTIM toggles.
    ir = 8'h00;
    tick(4);
    ir = 8'hFF;
    expect_at(3, "all_edges",     8'hFF, 1'b0, 3'd0);
    expect_at(4, "all_edges_id",  8'hFF, 1'b1, 3'd3);
    tick(4);
    LTIM = 1'b1;
    expect_at(1, "toggle_lvl_flush", 8'h00, 1'b1, 3'd3);
    expect_at(2, "toggle_lvl_fill",  8'hFF, 1'b0, 3'd0);
    expect_at(3, "toggle_lvl_id",    8'hFF, 1'b1, 3'd3);
    tick(3);
    LTIM = 1'b0;
    expect_at(1, "toggle_edge_flush", 8'h00, 1'b1, 3'd3);
    expect_at(2, "toggle_edge_req",   8'h00, 1'b0, 3'd0);
    expect_at(6, "toggle_edge_noset", 8'h00, 1'b0, 3'd0);
    tick(6);

    // Reset mid-operation.
    LTIM = 1'b1;
    expect_at(2, "pre_reset_fill", 8'hFF, 1'b0, 3'd0);
    expect_at(3, "pre_reset_id",   8'hFF, 1'b1, 3'd3);
    tick(3);
    reset = 1'b1;
    expect_at(1, "mid_reset", 8'h00, 1'b0, 3'd0);
    tick(1);
    reset = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: check for cycle %0d never performed", e.nm, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
